// File: rtl/led_multi_blink.sv
`default_nettype none
// ============================================================================
//  Module   : led_multi_blink
//  Purpose  : Multi-channel, run-time programmable LED timer. Each channel
//             owns a free-running counter that wraps at its own terminal
//             count and drives one LED in one of four modes (off, on,
//             50% blink, one-cycle strobe). A per-channel terminal flag is
//             exported as a timebase tick for neighbouring logic.
//
//  Ports    :
//    sys_clk    in   1        system clock
//    sys_rst_n  in   1        asynchronous active-low reset
//    en         in   1        global run enable, 0 freezes every channel
//    cfg_wr     in   1        single-cycle config write strobe
//    cfg_ch     in   CH_W     channel addressed by the write
//    cfg_mode   in   2        0 off, 1 on, 2 blink, 3 strobe
//    cfg_max    in   CNT_W    new terminal count for the addressed channel
//    led_out    out  CH_NUM   registered LED drive, bit i = channel i
//    cnt_flag   out  CH_NUM   registered, bit i high while cnt[i] == max[i]
//
//  Revision : 1.0  initial release
// ============================================================================

module led_multi_blink #(
   parameter int unsigned CH_NUM   = 4,
   parameter int unsigned CH_W     = 2,
   parameter int unsigned CNT_W    = 25,
   parameter int unsigned DEF_MAX  = 24,
   parameter logic [1:0]  DEF_MODE = 2'd2
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              en,
   input  logic              cfg_wr,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [1:0]        cfg_mode,
   input  logic [CNT_W-1:0]  cfg_max,
   output logic [CH_NUM-1:0] led_out,
   output logic [CH_NUM-1:0] cnt_flag
);

   // ------------------------------------------------------------------------
   // Mode encoding and reset values
   // ------------------------------------------------------------------------
   localparam logic [1:0]       c_MODE_OFF    = 2'd0;
   localparam logic [1:0]       c_MODE_ON     = 2'd1;
   localparam logic [1:0]       c_MODE_BLINK  = 2'd2;
   localparam logic [1:0]       c_MODE_STROBE = 2'd3;

   localparam logic [CNT_W-1:0] c_DEF_MAX     = CNT_W'(DEF_MAX);
   localparam logic             c_DEF_FLAG    = (DEF_MAX == 0);
   localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);

   // ------------------------------------------------------------------------
   // Per-channel timer
   // ------------------------------------------------------------------------
   for (genvar i = 0; i < CH_NUM; i++) begin : g_ch

      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] r_max;
      logic [1:0]       r_mode;
      logic             r_led;
      logic             r_flag;

      logic             w_wr_hit;
      logic             w_term;
      logic [CNT_W-1:0] w_cnt_nxt;

      // Addresses at or above CH_NUM never match any generated index, so
      // such writes fall through without touching any channel.
      assign w_wr_hit  = cfg_wr && (cfg_ch == CH_W'(i));

      // The flag register always equals (cnt == max), so it doubles as the
      // terminal-count detect and saves a second comparator per channel.
      assign w_term    = r_flag;

      // cnt <= max always holds, so the increment cannot wrap.
      assign w_cnt_nxt = w_term ? '0 : (r_cnt + c_CNT_ONE);

      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
         if (!sys_rst_n) begin
            r_cnt  <= '0;
            r_max  <= c_DEF_MAX;
            r_mode <= DEF_MODE;
            r_led  <= 1'b0;
            r_flag <= c_DEF_FLAG;
         end else if (w_wr_hit) begin
            // A write restarts the channel and wins over a coincident
            // terminal count, so no toggle/strobe happens on this edge.
            r_cnt  <= '0;
            r_max  <= cfg_max;
            r_mode <= cfg_mode;
            r_led  <= (cfg_mode == c_MODE_ON);
            r_flag <= (cfg_max == '0);
         end else if (en) begin
            r_cnt  <= w_cnt_nxt;
            // Look-ahead on the next count keeps the flag registered yet
            // exactly aligned with the cycle in which cnt == max.
            r_flag <= (w_cnt_nxt == r_max);
            case (r_mode)
               c_MODE_OFF:    r_led <= 1'b0;
               c_MODE_ON:     r_led <= 1'b1;
               c_MODE_BLINK:  r_led <= r_led ^ w_term;
               c_MODE_STROBE: r_led <= w_term;
               default:       r_led <= 1'b0;
            endcase
         end
      end

      assign led_out[i]  = r_led;
      assign cnt_flag[i] = r_flag;

   end : g_ch

endmodule : led_multi_blink

`default_nettype wire

// File: tb/tb_led_multi_blink.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_multi_blink
//  Purpose  : Self-checking bench for led_multi_blink. A behavioural model
//             tracks, per channel, the number of enabled cycles since the
//             last restart and derives the expected LED / flag values
//             arithmetically; directed phases add literal expectations.
//  Revision : 1.0  initial release
// ============================================================================

module tb_led_multi_blink;

   localparam int CH_NUM = 4;
   localparam int CH_W   = 3;
   localparam int CNT_W  = 25;
   localparam int DMAX   = 24;

   logic              sys_clk;
   logic              sys_rst_n;
   logic              en;
   logic              cfg_wr;
   logic [CH_W-1:0]   cfg_ch;
   logic [1:0]        cfg_mode;
   logic [CNT_W-1:0]  cfg_max;
   logic [CH_NUM-1:0] led_out;
   logic [CH_NUM-1:0] cnt_flag;

   int n_checks = 0;
   int n_fail   = 0;

   led_multi_blink #(
      .CH_NUM  (CH_NUM),
      .CH_W    (CH_W),
      .CNT_W   (CNT_W),
      .DEF_MAX (DMAX),
      .DEF_MODE(2'd2)
   ) dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .en       (en),
      .cfg_wr   (cfg_wr),
      .cfg_ch   (cfg_ch),
      .cfg_mode (cfg_mode),
      .cfg_max  (cfg_max),
      .led_out  (led_out),
      .cnt_flag (cnt_flag)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // ------------------------------------------------------------------------
   // Behavioural model: per channel, k = enabled edges since last restart.
   // cnt = k mod (max+1); blink LED = parity of completed periods; strobe
   // LED high right after a completed period.
   // ------------------------------------------------------------------------
   longint m_k    [CH_NUM];
   longint m_max  [CH_NUM];
   int     m_mode [CH_NUM];
   bit     m_led0 [CH_NUM];

   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int c = 0; c < CH_NUM; c++) begin
            m_k[c]    <= 0;
            m_max[c]  <= DMAX;
            m_mode[c] <= 2;
            m_led0[c] <= 1'b0;
         end
      end else begin
         for (int c = 0; c < CH_NUM; c++) begin
            if (cfg_wr && (int'(cfg_ch) == c)) begin
               m_k[c]    <= 0;
               m_max[c]  <= longint'(cfg_max);
               m_mode[c] <= int'(cfg_mode);
               m_led0[c] <= (cfg_mode == 2'd1);
            end else if (en) begin
               m_k[c] <= m_k[c] + 1;
            end
         end
      end
   end

   function automatic bit exp_led(int c);
      longint p = m_max[c] + 1;
      case (m_mode[c])
         0:       return 1'b0;
         1:       return (m_k[c] == 0) ? m_led0[c] : 1'b1;
         2:       return m_led0[c] ^ bit'((m_k[c] / p) % 2);
         default: return (m_k[c] == 0) ? m_led0[c] : ((m_k[c] % p) == 0);
      endcase
   endfunction

   function automatic bit exp_flag(int c);
      return ((m_k[c] % (m_max[c] + 1)) == m_max[c]);
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge sys_clk) begin
      logic [CH_NUM-1:0] e_led;
      logic [CH_NUM-1:0] e_flag;
      for (int c = 0; c < CH_NUM; c++) begin
         e_led[c]  = exp_led(c);
         e_flag[c] = exp_flag(c);
      end
      check("model_led_out",  32'(led_out),  32'(e_led));
      check("model_cnt_flag", 32'(cnt_flag), 32'(e_flag));
   end

   task automatic tick(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic write(input int ch, input logic [1:0] mode, input int mx);
      cfg_wr   = 1'b1;
      cfg_ch   = CH_W'(ch);
      cfg_mode = mode;
      cfg_max  = CNT_W'(mx);
      tick(1);
      cfg_wr   = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   // Directed phases with literal expectations
   // ------------------------------------------------------------------------
   initial begin
      sys_rst_n = 1'b0;
      en        = 1'b1;
      cfg_wr    = 1'b0;
      cfg_ch    = '0;
      cfg_mode  = 2'd0;
      cfg_max   = '0;

      #3;
      check("reset_led",  32'(led_out),  32'h0);
      check("reset_flag", 32'(cnt_flag), 32'h0);
      tick(3);
      sys_rst_n = 1'b1;

      // Default blink, max 24: flag after 24 edges, first LED rise at 25.
      tick(24);
      check("def_flag_at_24", 32'(cnt_flag), 32'hF);
      check("def_led_at_24",  32'(led_out),  32'h0);
      tick(1);
      check("def_led_at_25",  32'(led_out),  32'hF);
      check("def_flag_at_25", 32'(cnt_flag), 32'h0);

      // ch1 strobe, max 4.
      write(1, 2'd3, 4);
      check("ch1_led_after_wr",  32'(led_out[1]),  32'h0);
      check("ch1_flag_after_wr", 32'(cnt_flag[1]), 32'h0);
      tick(4);
      check("ch1_flag_term", 32'(cnt_flag[1]), 32'h1);
      check("ch1_led_term",  32'(led_out[1]),  32'h0);
      tick(1);
      check("ch1_strobe_hi", 32'(led_out[1]), 32'h1);
      tick(1);
      check("ch1_strobe_lo", 32'(led_out[1]), 32'h0);

      // ch2 blink, max 0, then on.
      write(2, 2'd2, 0);
      check("ch2_flag_max0", 32'(cnt_flag[2]), 32'h1);
      check("ch2_led_wr",    32'(led_out[2]),  32'h0);
      tick(1);
      check("ch2_led_t1",    32'(led_out[2]),  32'h1);
      tick(1);
      check("ch2_led_t2",    32'(led_out[2]),  32'h0);
      write(2, 2'd1, 0);
      check("ch2_on",        32'(led_out[2]),  32'h1);
      tick(3);
      check("ch2_on_held",   32'(led_out[2]),  32'h1);
      check("ch2_flag_held", 32'(cnt_flag[2]), 32'h1);

      // ch0 blink, max 9, en dropped for 7 cycles at cnt 5.
      write(0, 2'd2, 9);
      tick(5);
      en = 1'b0;
      tick(7);
      check("ch0_frozen_flag", 32'(cnt_flag[0]), 32'h0);
      check("ch0_frozen_led",  32'(led_out[0]),  32'h0);
      en = 1'b1;
      tick(3);
      check("ch0_flag_cnt8", 32'(cnt_flag[0]), 32'h0);
      tick(1);
      check("ch0_flag_cnt9", 32'(cnt_flag[0]), 32'h1);
      check("ch0_led_cnt9",  32'(led_out[0]),  32'h0);
      tick(1);
      check("ch0_toggle",    32'(led_out[0]),  32'h1);

      // ch3 write landing on its terminal cycle.
      for (int w = 0; w < 60 && !cnt_flag[3]; w++) @(negedge sys_clk);
      check("ch3_term_seen", 32'(cnt_flag[3]), 32'h1);
      write(3, 2'd3, 3);
      check("ch3_no_strobe", 32'(led_out[3]),  32'h0);
      check("ch3_cnt0_flag", 32'(cnt_flag[3]), 32'h0);
      tick(3);
      check("ch3_flag_3",    32'(cnt_flag[3]), 32'h1);
      tick(1);
      check("ch3_strobe",    32'(led_out[3]),  32'h1);

      // Out-of-range channel writes are ignored.
      write(5, 2'd1, 0);
      check("ch5_ignored_led",  32'(led_out[3]),  32'h0);
      check("ch5_ignored_flag", 32'(cnt_flag[3]), 32'h0);
      write(4, 2'd0, 0);
      tick(3);

      // Asynchronous reset in the middle of a write.
      cfg_wr   = 1'b1;
      cfg_ch   = 3'd0;
      cfg_mode = 2'd1;
      cfg_max  = '0;
      #2 sys_rst_n = 1'b0;
      #1;
      check("async_rst_led",  32'(led_out),  32'h0);
      check("async_rst_flag", 32'(cnt_flag), 32'h0);
      tick(1);
      cfg_wr = 1'b0;
      tick(2);
      sys_rst_n = 1'b1;
      tick(24);
      check("rerst_flag_24", 32'(cnt_flag), 32'hF);
      check("rerst_led_24",  32'(led_out),  32'h0);
      tick(1);
      check("rerst_led_25",  32'(led_out),  32'hF);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule : tb_led_multi_blink

`default_nettype wire
